// File: rtl/vco_cal_seq.sv
// VCO coarse-calibration sequencer: SAR search over the capacitor load code,
// settling each trial for rampTime+1 cycles before sampling the synced Vup/Vdn.
module vco_cal_seq #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             PD,
  input  logic             Vco_fixed_select,
  input  logic [WIDTH-1:0] fixed_code,
  input  logic [7:0]       rampTime,
  input  logic             Vup,
  input  logic             Vdn,
  output logic [WIDTH-1:0] load_select,
  output logic [4:0]       count,
  output logic             busy,
  output logic             done,
  output logic             cal_err
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MSB_CODE = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] vup_sync, vdn_sync;
  logic                   vu, vd;
  logic [7:0]             timer, timer_n;
  logic [IW-1:0]          idx, idx_n;
  logic [WIDTH-1:0]       load_n;
  logic [4:0]             count_n;
  logic                   busy_n, done_n, err_n;

  assign vu = vup_sync[SYNC_STAGES-1];
  assign vd = vdn_sync[SYNC_STAGES-1];

  // Comparator synchronizers; the raw inputs are never used directly.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      vup_sync <= '0;
      vdn_sync <= '0;
    end else begin
      vup_sync <= {vup_sync[SYNC_STAGES-2:0], Vup};
      vdn_sync <= {vdn_sync[SYNC_STAGES-2:0], Vdn};
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      idx         <= '0;
      load_select <= MSB_CODE;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cal_err     <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      idx         <= idx_n;
      load_select <= load_n;
      count       <= count_n;
      busy        <= busy_n;
      done        <= done_n;
      cal_err     <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = idx;
    load_n  = load_select;
    count_n = count;
    busy_n  = busy;
    done_n  = done;
    err_n   = cal_err;

    // Power-down overrides everything; code and step count are kept for readback.
    if (PD) begin
      state_n = IDLE;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            count_n = '0;
            err_n   = 1'b0;
            if (Vco_fixed_select) begin
              load_n  = fixed_code;
              done_n  = 1'b1;
              busy_n  = 1'b0;
              state_n = DONE;
            end else begin
              load_n  = MSB_CODE;
              idx_n   = IW'(WIDTH - 1);
              timer_n = rampTime;
              busy_n  = 1'b1;
              done_n  = 1'b0;
              state_n = SETTLE;
            end
          end
        end

        SETTLE: begin
          if (timer == 8'd0) state_n = SAMPLE;
          else               timer_n = timer - 8'd1;
        end

        SAMPLE: begin
          count_n = count + 5'd1;
          if (vu && vd) begin
            err_n   = 1'b1;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = DONE;
          end else if (!vu && !vd) begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = DONE;
          end else begin
            if (vu) load_n[idx] = 1'b0;
            if (idx == '0) begin
              done_n  = 1'b1;
              busy_n  = 1'b0;
              state_n = DONE;
            end else begin
              load_n[idx - IW'(1)] = 1'b1;
              idx_n   = idx - IW'(1);
              timer_n = rampTime;
              state_n = SETTLE;
            end
          end
        end

        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vco_cal_seq.sv
// Self-checking bench for vco_cal_seq: directed scenarios plus randomized SAR runs
// checked against an arithmetic model of the successive-approximation search.
module tb_vco_cal_seq;

  localparam int W    = 5;
  localparam int SYNC = 2;

  // Comparator decisions used by the model and the stimulus.
  localparam int KEEP  = 0;
  localparam int CLEAR = 1;
  localparam int LOCK  = 2;
  localparam int INVAL = 3;

  logic         CLK = 1'b0;
  logic         reset;
  logic         start;
  logic         PD;
  logic         Vco_fixed_select;
  logic [W-1:0] fixed_code;
  logic [7:0]   rampTime;
  logic         Vup;
  logic         Vdn;
  logic [W-1:0] load_select;
  logic [4:0]   count;
  logic         busy;
  logic         done;
  logic         cal_err;

  int checks   = 0;
  int failures = 0;
  int dec[W];

  vco_cal_seq #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .CLK              (CLK),
    .reset            (reset),
    .start            (start),
    .PD               (PD),
    .Vco_fixed_select (Vco_fixed_select),
    .fixed_code       (fixed_code),
    .rampTime         (rampTime),
    .Vup              (Vup),
    .Vdn              (Vdn),
    .load_select      (load_select),
    .count            (count),
    .busy             (busy),
    .done             (done),
    .cal_err          (cal_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmp(input int d);
    Vup = (d == CLEAR) || (d == INVAL);
    Vdn = (d == KEEP)  || (d == INVAL);
  endtask

  // Runs one search with decisions dec[] and ramp r; checks every trial code and the result.
  task automatic run_cal(input string name, input int r);
    logic [W-1:0] trial[W];
    logic [W-1:0] code;
    int           n;
    logic         err;
    code = W'(1) << (W - 1);
    n    = 0;
    err  = 1'b0;
    for (int k = 0; k < W; k++) begin
      trial[k] = code;
      n++;
      if (dec[k] == INVAL) begin err = 1'b1; break; end
      if (dec[k] == LOCK) break;
      if (dec[k] == CLEAR) code[W-1-k] = 1'b0;
      if (k < W - 1) code[W-2-k] = 1'b1;
    end

    rampTime = 8'(r);
    Vco_fixed_select = 1'b0;
    set_cmp(dec[0]);
    repeat (SYNC + 1) @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    for (int k = 0; k < n; k++) begin
      check({name, "_trial_code"}, 32'(load_select), 32'(trial[k]));
      check({name, "_trial_busy"}, 32'(busy), 32'd1);
      check({name, "_trial_done"}, 32'(done), 32'd0);
      check({name, "_trial_count"}, 32'(count), 32'(k));
      repeat (r + 2) @(posedge CLK);
      #1;
      if (k + 1 < n) set_cmp(dec[k+1]);
    end
    check({name, "_final_code"}, 32'(load_select), 32'(code));
    check({name, "_final_count"}, 32'(count), 32'(n));
    check({name, "_final_done"}, 32'(done), 32'd1);
    check({name, "_final_busy"}, 32'(busy), 32'd0);
    check({name, "_final_err"}, 32'(cal_err), 32'(err));
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    PD = 1'b0;
    Vco_fixed_select = 1'b0;
    fixed_code = '0;
    rampTime = 8'd0;
    Vup = 1'b0;
    Vdn = 1'b0;

    #12;
    check("reset_load", 32'(load_select), 32'h10);
    check("reset_count", 32'(count), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(cal_err), 32'd0);
    @(negedge CLK);
    reset = 1'b1;

    // Full search, keep every bit: 25 cycles to done, code 11111.
    for (int k = 0; k < W; k++) dec[k] = KEEP;
    run_cal("keep_all", 3);

    // Full search, clear every bit with minimum settle.
    for (int k = 0; k < W; k++) dec[k] = CLEAR;
    run_cal("clear_all", 0);

    // Early lock after two keeps.
    dec[0] = KEEP; dec[1] = KEEP; dec[2] = LOCK; dec[3] = KEEP; dec[4] = KEEP;
    run_cal("early_lock", 3);

    // Invalid comparator state at the first sample.
    dec[0] = INVAL;
    run_cal("invalid", 2);

    // Fixed-code bypass.
    @(negedge CLK);
    Vco_fixed_select = 1'b1;
    fixed_code = 5'b01101;
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    Vco_fixed_select = 1'b0;
    check("fixed_load", 32'(load_select), 32'h0D);
    check("fixed_done", 32'(done), 32'd1);
    check("fixed_busy", 32'(busy), 32'd0);
    check("fixed_count", 32'(count), 32'd0);
    check("fixed_err", 32'(cal_err), 32'd0);

    // Start while busy (requesting bypass) must be ignored, then PD aborts.
    set_cmp(KEEP);
    rampTime = 8'd6;
    repeat (SYNC + 1) @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    @(posedge CLK);
    #1 start = 1'b1;
    Vco_fixed_select = 1'b1;
    fixed_code = 5'b00011;
    @(posedge CLK);
    #1 start = 1'b0;
    Vco_fixed_select = 1'b0;
    check("busy_start_busy", 32'(busy), 32'd1);
    check("busy_start_done", 32'(done), 32'd0);
    check("busy_start_load", 32'(load_select), 32'h10);
    PD = 1'b1;
    @(posedge CLK);
    #1;
    check("pd_busy", 32'(busy), 32'd0);
    check("pd_done", 32'(done), 32'd0);
    check("pd_load", 32'(load_select), 32'h10);
    check("pd_count", 32'(count), 32'd0);
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    check("pd_start_busy", 32'(busy), 32'd0);
    check("pd_start_done", 32'(done), 32'd0);
    @(negedge CLK);
    PD = 1'b0;

    // Randomized searches against the model.
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < W; k++) begin
        int p;
        p = int'($urandom_range(0, 99));
        dec[k] = (p < 42) ? KEEP : (p < 84) ? CLEAR : (p < 92) ? LOCK : INVAL;
      end
      run_cal($sformatf("rand%0d", t), int'($urandom_range(2, 7)));
    end

    // Async reset in the middle of a run.
    for (int k = 0; k < W; k++) dec[k] = KEEP;
    set_cmp(KEEP);
    rampTime = 8'd5;
    repeat (SYNC + 1) @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (9) @(posedge CLK);
    #3 reset = 1'b0;
    #1;
    check("midrst_load", 32'(load_select), 32'h10);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    @(negedge CLK);
    reset = 1'b1;
    repeat (2) @(posedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
